// File: rtl/dual_camera_pkg.sv
// Shared definitions for the dual-camera read path: packed FIFO word layout,
// pixel width and the unpacker state type.
package dual_camera_pkg;

  localparam int unsigned WORD_W   = 32;
  localparam int unsigned PIX_W    = 10;
  localparam int unsigned SOF_BIT  = 31;
  localparam int unsigned SOL_BIT  = 30;
  localparam int unsigned PIX0_MSB = 29;
  localparam int unsigned PIX0_LSB = 20;
  localparam int unsigned PIX1_MSB = 19;
  localparam int unsigned PIX1_LSB = 10;
  localparam int unsigned PIX2_MSB = 9;
  localparam int unsigned PIX2_LSB = 0;

  typedef enum logic {StIdle, StEmit} unpack_state_e;

  function automatic logic [PIX_W-1:0] word_pixel(input logic [WORD_W-1:0] word,
                                                  input logic [1:0]        idx);
    case (idx)
      2'd0:    return word[PIX0_MSB:PIX0_LSB];
      2'd1:    return word[PIX1_MSB:PIX1_LSB];
      default: return word[PIX2_MSB:PIX2_LSB];
    endcase
  endfunction

endpackage

// File: rtl/raw10_fifo_unpacker_if.sv
// RAW10 pixel stream: one 10-bit pixel per beat with frame/line start markers.
interface raw10_fifo_unpacker_if import dual_camera_pkg::*; ();

  logic [PIX_W-1:0] pix_data;
  logic             pix_sof;
  logic             pix_sol;
  logic             pix_valid;
  logic             pix_ready;

  modport master (output pix_data, pix_sof, pix_sol, pix_valid, input pix_ready);
  modport slave  (input pix_data, pix_sof, pix_sol, pix_valid, output pix_ready);

endinterface

// File: rtl/raw10_skid_fifo.sv
// Small synchronous word FIFO with fall-through read data and an occupancy count.
module raw10_skid_fifo import dual_camera_pkg::*; #(
  parameter int unsigned Depth = 2,
  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1,
  localparam int unsigned CntW = $clog2(Depth + 1)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              wr_en_i,
  input  logic [WORD_W-1:0] wr_data_i,
  input  logic              rd_en_i,
  output logic [WORD_W-1:0] rd_data_o,
  output logic [CntW-1:0]   count_o
);

  logic [WORD_W-1:0] mem_q [Depth];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]   count_q;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_en_i) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (rd_en_i) rd_ptr_q <= ptr_inc(rd_ptr_q);
      count_q <= count_q + CntW'(wr_en_i) - CntW'(rd_en_i);
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en_i) mem_q[wr_ptr_q] <= wr_data_i;
  end

  assign rd_data_o = mem_q[rd_ptr_q];
  assign count_o   = count_q;

endmodule

// File: rtl/raw10_fifo_unpacker.sv
// Read side of the packed RAW10 FIFO: issues reads, tracks read latency, unpacks 3 pixels/word.
// Optional per-line pixel counter enabled by defining RAW10_PIXCNT_EN.
module raw10_fifo_unpacker import dual_camera_pkg::*; #(
  parameter int unsigned RD_LATENCY = 1,
  parameter int unsigned BUF_WORDS  = 2
) (
  input  logic                  RdClock,
  input  logic                  Reset_n,
  input  logic                  enable,
  input  logic [WORD_W-1:0]     fifo_Q,
  input  logic                  fifo_Empty,
  output logic                  fifo_RdEn,
  raw10_fifo_unpacker_if.master pix,
  output logic                  busy
`ifdef RAW10_PIXCNT_EN
  ,
  output logic [15:0]           line_pixels,
  output logic                  short_line
`endif
);

  localparam int unsigned CntW  = $clog2(BUF_WORDS + 1);
  localparam int unsigned InflW = $clog2(RD_LATENCY + 1);

  logic [RD_LATENCY-1:0] lat_q, lat_d;
  logic [InflW-1:0]      in_flight;
  logic                  capture;

  logic [WORD_W-1:0]     buf_head;
  logic [CntW-1:0]       buf_count;
  logic                  buf_wr, buf_rd, buf_empty;

  unpack_state_e         state_q, state_d;
  logic [1:0]            idx_q, idx_d;
  logic [WORD_W-1:0]     word_q, word_d;
  logic                  hs, avail, load;
  logic [WORD_W-1:0]     next_word;

  always_comb begin
    in_flight = '0;
    for (int i = 0; i < RD_LATENCY; i++) in_flight += InflW'(lat_q[i]);
  end

  assign fifo_RdEn = Reset_n & enable & ~fifo_Empty &
                     ((32'(in_flight) + 32'(buf_count)) < BUF_WORDS);

  // Bit i set: a read issued i+1 cycles ago; the MSB marks the word now on fifo_Q.
  always_comb begin
    lat_d    = lat_q << 1;
    lat_d[0] = fifo_RdEn;
  end
  assign capture = lat_q[RD_LATENCY-1];

  raw10_skid_fifo #(
    .Depth (BUF_WORDS)
  ) u_skid (
    .clk_i     (RdClock),
    .rst_ni    (Reset_n),
    .wr_en_i   (buf_wr),
    .wr_data_i (fifo_Q),
    .rd_en_i   (buf_rd),
    .rd_data_o (buf_head),
    .count_o   (buf_count)
  );

  assign pix.pix_valid = (state_q == StEmit);
  assign pix.pix_data  = pix.pix_valid ? word_pixel(word_q, idx_q) : '0;
  assign pix.pix_sof   = pix.pix_valid & (idx_q == 2'd0) & word_q[SOF_BIT];
  assign pix.pix_sol   = pix.pix_valid & (idx_q == 2'd0) & (word_q[SOL_BIT] | word_q[SOF_BIT]);
  assign busy          = (in_flight != '0) | (buf_count != '0) | (state_q == StEmit);

  // An empty skid buffer is bypassed so a captured word can be loaded directly.
  always_comb begin
    hs        = pix.pix_valid & pix.pix_ready;
    buf_empty = (buf_count == '0);
    avail     = ~buf_empty | capture;
    next_word = buf_empty ? fifo_Q : buf_head;
    load      = avail & ((state_q == StIdle) | (hs & (idx_q == 2'd2)));
    buf_rd    = load & ~buf_empty;
    buf_wr    = capture & ~(load & buf_empty);

    state_d = state_q;
    idx_d   = idx_q;
    word_d  = word_q;
    unique case (state_q)
      StIdle: begin
        if (load) begin
          state_d = StEmit;
          idx_d   = 2'd0;
          word_d  = next_word;
        end
      end
      StEmit: begin
        if (hs) begin
          if (idx_q != 2'd2) begin
            idx_d = idx_q + 2'd1;
          end else if (load) begin
            idx_d  = 2'd0;
            word_d = next_word;
          end else begin
            state_d = StIdle;
            idx_d   = 2'd0;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge RdClock or negedge Reset_n) begin
    if (!Reset_n) begin
      lat_q   <= '0;
      state_q <= StIdle;
      idx_q   <= '0;
      word_q  <= '0;
    end else begin
      lat_q   <= lat_d;
      state_q <= state_d;
      idx_q   <= idx_d;
      word_q  <= word_d;
    end
  end

`ifdef RAW10_PIXCNT_EN
  logic [15:0] pix_cnt_q, line_pixels_q;
  logic        short_q, first_line_q;

  // first_line_q suppresses the length compare for the line that follows an SOF.
  always_ff @(posedge RdClock or negedge Reset_n) begin
    if (!Reset_n) begin
      pix_cnt_q     <= '0;
      line_pixels_q <= '0;
      short_q       <= 1'b0;
      first_line_q  <= 1'b1;
    end else begin
      short_q <= 1'b0;
      if (hs) begin
        if (pix.pix_sol) begin
          pix_cnt_q     <= 16'd1;
          line_pixels_q <= pix_cnt_q;
          short_q       <= ~first_line_q & (pix_cnt_q != line_pixels_q);
          first_line_q  <= pix.pix_sof;
        end else begin
          pix_cnt_q <= pix_cnt_q + 16'd1;
        end
      end
    end
  end

  assign line_pixels = line_pixels_q;
  assign short_line  = short_q;
`endif

endmodule
